fpu_issue: RTL and testbench
============================

Name: fpu_issue

Overview:
- In-order issue/retire front end for the FPU execution units: fmul, fadd/fsub, fdiv, fsqrt.
- Takes one FP op per handshake from the core and drives order/accepted on the selected unit.
- Captures each unit's one-cycle done/rd result and writes results back to the FP register file strictly in issue order, tagged with the destination register.

Parameters:
NUM_UNITS, 4, number of attached units; index width UW = clog2(NUM_UNITS)
TAG_W, 6, destination-register tag width
DEPTH, 4, max in-flight ops (power of two)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
op_valid  in  1  core presents an op
op_ready  out  1  op taken this cycle
op_unit  in  UW  target unit index
op_tag  in  TAG_W  destination register
op_rs1  in  32  operand 1
op_rs2  in  32  operand 2
unit_order  out  NUM_UNITS  one-hot order to units
unit_accepted  in  NUM_UNITS  per-unit accepted
unit_done  in  NUM_UNITS  per-unit done (result valid this cycle only)
unit_rs1  out  32  shared operand 1 (= op_rs1)
unit_rs2  out  32  shared operand 2 (= op_rs2)
unit_rd  in  32*NUM_UNITS  results, unit u at [32u+31:32u]
wb_valid  out  1  writeback strobe
wb_tag  out  TAG_W  writeback register
wb_data  out  32  writeback value
busy  out  1  any op in flight
proto_err  out  1  sticky: done from a unit with no pending op

Behaviour:
- Reset (rstn=0 at posedge): all slots empty, order FIFO empty, wb_valid=0, wb_tag=0, wb_data=0, proto_err=0.
  - unit_order is combinationally 0 while every slot is empty.
  - Units share rstn, so a reset mid-operation discards all in-flight work; done pulses arriving after reset set proto_err.
- Per-unit slot u: states EMPTY -> PENDING (issued) -> DONE (result held) -> EMPTY (retired). Each slot holds the tag and a 32-bit result. One op in flight per unit.
- Issue (combinational):
  - unit_order[u] = op_valid & (op_unit==u) & slot[u]==EMPTY at cycle start & FIFO not full.
  - op_ready = unit_accepted[op_unit] & unit_order[op_unit].
  - On op_ready the slot goes PENDING, the tag is stored, and op_unit is pushed to the order FIFO.
  - The core holds op_* stable until op_ready.
- Done: unit_done[u] with slot PENDING -> result = unit_rd[u] captured, slot goes DONE. With slot not PENDING -> ignored, proto_err <= 1.
- Retire:
  - Head h = FIFO head. Retire when slot[h]==DONE, or slot[h]==PENDING & unit_done[h] (bypass; data taken from unit_rd[h]).
  - On retire: pop FIFO, slot[h] <= EMPTY, and next cycle wb_valid=1, wb_tag=slot tag, wb_data=result.
  - At most one retire per cycle; wb has no back-pressure.
- Latency: fmul handshake in cycle T -> done at T+2 -> wb_valid in T+3 if it is at the FIFO head.
- Simultaneous events:
  - Issue and retire in the same cycle are both allowed.
  - A slot freed this cycle is not issuable until the next cycle.
  - Full is evaluated on the start-of-cycle count (no same-cycle pop credit).
  - done on several units in the same cycle: all are captured; only the head may retire.
- busy = FIFO non-empty. Count arithmetic is mod 2*DEPTH pointers; full when count==DEPTH.

Decomposition:
- Package fpu_pkg: unit index constants (FMUL=0, FADD=1, FDIV=2, FSQRT=3), UW, TAG_W.
- Sub-module fpu_order_fifo: DEPTH x UW synchronous FIFO with push/pop/full/empty/head, same clock and reset.

Test Plan:
- fmul 2.0*3.0: op_unit=0, rs1=0x40000000, rs2=0x40400000, tag=5, handshake T -> wb_valid at T+3, wb_tag=5, wb_data=0x40C00000 (model: unit 0 = 2-cycle done, 3-cycle accepted-to-writeback).
- Ordering: fadd model (latency 4) tag=1 issued T, fmul tag=2 issued T+1 -> fmul done T+3 is held (DONE); wb order is tag 1 at T+5, then tag 2 at T+6.
- Unit busy: two consecutive ops to unit 0 -> second gets op_ready=0 until the first retires; the second handshake occurs in the cycle after the retire.
- FIFO full: 4 ops outstanding on units 0-3 with done withheld -> 5th op_valid sees op_ready=0 and unit_order=0; release one done -> issue resumes the following cycle.
- Spurious done: unit_done[2]=1 with slot 2 EMPTY -> proto_err=1 and stays 1; no wb_valid.
- Reset mid-flight: rstn=0 for 1 cycle with 3 ops pending -> busy=0, wb_valid=0, proto_err=0 next cycle; a fresh op completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU issue/retire front end.
package fpu_pkg;
    localparam int NUM_UNITS = 4;
    localparam int UW        = $clog2(NUM_UNITS);
    localparam int TAG_W     = 6;
    localparam int DEPTH     = 4;

    localparam logic [UW-1:0] FMUL  = UW'(0);
    localparam logic [UW-1:0] FADD  = UW'(1);
    localparam logic [UW-1:0] FDIV  = UW'(2);
    localparam logic [UW-1:0] FSQRT = UW'(3);

    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_DONE    = 2'd2
    } slot_st_e;
endpackage

// File: rtl/fpu_issue_if.sv
// Core/unit/writeback signal bundle of the FPU issue block.
interface fpu_issue_if #(
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 6
);
    localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    // Handshakes: an op transfers on a cycle where op_valid && op_ready; the core
    // holds op_* stable until then. A unit takes its order when unit_order[u] &&
    // unit_accepted[u]. unit_done and wb_valid are single-cycle strobes, no stall.
    logic                   op_valid;
    logic                   op_ready;
    logic [IW-1:0]          op_unit;
    logic [TAG_W-1:0]       op_tag;
    logic [31:0]            op_rs1;
    logic [31:0]            op_rs2;
    logic [NUM_UNITS-1:0]   unit_order;
    logic [NUM_UNITS-1:0]   unit_accepted;
    logic [NUM_UNITS-1:0]   unit_done;
    logic [31:0]            unit_rs1;
    logic [31:0]            unit_rs2;
    logic [32*NUM_UNITS-1:0] unit_rd;
    logic                   wb_valid;
    logic [TAG_W-1:0]       wb_tag;
    logic [31:0]            wb_data;
    logic                   busy;
    logic                   proto_err;

    modport slave (
        input  op_valid, op_unit, op_tag, op_rs1, op_rs2,
        input  unit_accepted, unit_done, unit_rd,
        output op_ready, unit_order, unit_rs1, unit_rs2,
        output wb_valid, wb_tag, wb_data, busy, proto_err
    );

    modport master (
        output op_valid, op_unit, op_tag, op_rs1, op_rs2,
        output unit_accepted, unit_done, unit_rd,
        input  op_ready, unit_order, unit_rs1, unit_rs2,
        input  wb_valid, wb_tag, wb_data, busy, proto_err
    );
endinterface

// File: rtl/fpu_order_fifo.sv
// Issue-order FIFO of unit indices; pointers carry one wrap bit so full/empty are exact.
module fpu_order_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  count;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fpu_issue.sv
// In-order issue/retire front end: one op per unit in flight, results written back in issue order.
module fpu_issue #(
    parameter int NUM_UNITS = fpu_pkg::NUM_UNITS,
    parameter int TAG_W     = fpu_pkg::TAG_W,
    parameter int DEPTH     = fpu_pkg::DEPTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    fpu_issue_if.slave             bus,
    output logic [2*NUM_UNITS-1:0] dbg_slot_state
);
    import fpu_pkg::*;

    localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    slot_st_e         slot_q [NUM_UNITS];
    slot_st_e         slot_d [NUM_UNITS];
    logic [TAG_W-1:0] tag_q  [NUM_UNITS];
    logic [TAG_W-1:0] tag_d  [NUM_UNITS];
    logic [31:0]      res_q  [NUM_UNITS];
    logic [31:0]      res_d  [NUM_UNITS];
    logic [31:0]      rd_arr [NUM_UNITS];

    logic                 wb_valid_q, proto_err_q, proto_err_d;
    logic [TAG_W-1:0]     wb_tag_q, wb_tag_d;
    logic [31:0]          wb_data_q, wb_data_d;
    logic [NUM_UNITS-1:0] order;
    logic                 issue, retire;
    logic                 fifo_full, fifo_empty;
    logic [IW-1:0]        head;

    fpu_order_fifo #(.DEPTH(DEPTH), .W(IW)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (issue),
        .pop   (retire),
        .din   (bus.op_unit),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // Issue eligibility looks only at start-of-cycle slot state and FIFO count.
    always_comb begin
        order = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            order[u]  = bus.op_valid && (bus.op_unit == IW'(u)) &&
                        (slot_q[u] == SLOT_EMPTY) && !fifo_full;
            rd_arr[u] = bus.unit_rd[32*u +: 32];
        end
    end

    assign issue          = bus.unit_accepted[bus.op_unit] & order[bus.op_unit];
    assign bus.op_ready   = issue;
    assign bus.unit_order = order;
    assign bus.unit_rs1   = bus.op_rs1;
    assign bus.unit_rs2   = bus.op_rs2;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_tag     = wb_tag_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.busy       = !fifo_empty;
    assign bus.proto_err  = proto_err_q;

    always_comb begin
        slot_d      = slot_q;
        tag_d       = tag_q;
        res_d       = res_q;
        proto_err_d = proto_err_q;
        wb_tag_d    = wb_tag_q;
        wb_data_d   = wb_data_q;
        retire      = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (issue && (bus.op_unit == IW'(u))) begin
                slot_d[u] = SLOT_PENDING;
                tag_d[u]  = bus.op_tag;
            end
            if (bus.unit_done[u]) begin
                if (slot_q[u] == SLOT_PENDING) begin
                    slot_d[u] = SLOT_DONE;
                    res_d[u]  = rd_arr[u];
                end else begin
                    proto_err_d = 1'b1;
                end
            end
        end
        // Head retires from its held result, or straight off the unit bus when done arrives now.
        if (!fifo_empty) begin
            if (slot_q[head] == SLOT_DONE) begin
                retire    = 1'b1;
                wb_data_d = res_q[head];
            end else if ((slot_q[head] == SLOT_PENDING) && bus.unit_done[head]) begin
                retire    = 1'b1;
                wb_data_d = rd_arr[head];
            end
            if (retire) begin
                wb_tag_d     = tag_q[head];
                slot_d[head] = SLOT_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                slot_q[u] <= SLOT_EMPTY;
                tag_q[u]  <= '0;
                res_q[u]  <= '0;
            end
            wb_valid_q  <= 1'b0;
            wb_tag_q    <= '0;
            wb_data_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            tag_q       <= tag_d;
            res_q       <= res_d;
            wb_valid_q  <= retire;
            wb_tag_q    <= wb_tag_d;
            wb_data_q   <= wb_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        dbg_slot_state = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            dbg_slot_state[2*u +: 2] = slot_q[u];
        end
    end
endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue with behavioural unit models and an in-order writeback scoreboard.
module tb_fpu_issue;
    import fpu_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_issue_if #(.NUM_UNITS(NUM_UNITS), .TAG_W(TAG_W)) bus ();
    logic [2*NUM_UNITS-1:0] dbg;

    fpu_issue #(.NUM_UNITS(NUM_UNITS), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .bus            (bus),
        .dbg_slot_state (dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [TAG_W+31:0] exp_q [$];
    logic [TAG_W+31:0] mon_e;
    int               wb_cnt = 0;
    int               wb_log_cyc [$];
    logic [TAG_W-1:0] wb_log_tag [$];

    logic [NUM_UNITS-1:0] hold = '0;
    logic [NUM_UNITS-1:0] spur = '0;
    logic [31:0]          next_res [NUM_UNITS];
    int                   lat [NUM_UNITS] = '{2, 4, 6, 5};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every writeback pops the oldest expected {tag,data}.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
        end else if (bus.wb_valid === 1'b1) begin
            wb_cnt++;
            wb_log_cyc.push_back(cyc);
            wb_log_tag.push_back(bus.wb_tag);
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_tag", 64'(bus.wb_tag), 64'(mon_e[TAG_W+31:32]));
                chk("wb_data", 64'(bus.wb_data), 64'(mon_e[31:0]));
            end
        end
    end

    // Unit models: fixed latency from handshake to a one-cycle done; hold[u] withholds done.
    initial begin
        bit act [NUM_UNITS];
        int cnt [NUM_UNITS];
        logic [31:0] res [NUM_UNITS];
        logic [NUM_UNITS-1:0] d;
        bus.unit_done = '0;
        bus.unit_rd   = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            act[u] = 1'b0;
            cnt[u] = 0;
            res[u] = '0;
        end
        fork
            forever begin
                @(negedge clk);
                for (int u = 0; u < NUM_UNITS; u++) begin
                    if (!rstn) begin
                        act[u] = 1'b0;
                    end else if (bus.unit_order[u] && bus.unit_accepted[u]) begin
                        act[u] = 1'b1;
                        cnt[u] = lat[u];
                        res[u] = next_res[u];
                    end
                end
            end
            forever begin
                @(posedge clk);
                #1;
                d = '0;
                for (int u = 0; u < NUM_UNITS; u++) begin
                    if (act[u]) begin
                        if (cnt[u] > 0) cnt[u]--;
                        if (cnt[u] == 0 && !hold[u]) begin
                            d[u] = 1'b1;
                            bus.unit_rd[32*u +: 32] = res[u];
                            act[u] = 1'b0;
                        end
                    end
                end
                bus.unit_done = d | spur;
            end
        join
    end

    // Presents one op (entry and exit just after a posedge); returns the handshake cycle.
    task automatic issue(input logic [UW-1:0] u, input logic [TAG_W-1:0] tag,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, output int hs);
        int  waited = 0;
        bit  got    = 1'b0;
        hs          = -1;
        next_res[u] = res;
        bus.op_unit  = u;
        bus.op_tag   = tag;
        bus.op_rs1   = a;
        bus.op_rs2   = b;
        bus.op_valid = 1'b1;
        while (!got && waited < 50) begin
            @(negedge clk);
            if (bus.op_ready === 1'b1) begin
                got = 1'b1;
                hs  = cyc;
                exp_q.push_back({tag, res});
                chk("issue_order", 64'(bus.unit_order), 64'd1 << u);
                chk("issue_rs1", 64'(bus.unit_rs1), 64'(a));
                chk("issue_rs2", 64'(bus.unit_rs2), 64'(b));
            end else begin
                waited++;
            end
        end
        if (!got) chk("issue_timeout", 64'd0, 64'd1);
        to_pos();
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_wb(input int target);
        int b = 0;
        while (wb_cnt < target && b < 100) begin
            to_pos();
            b++;
        end
        if (wb_cnt < target) chk("wb_timeout", 64'(wb_cnt), 64'(target));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, ha, hb, h5, rel;
        bus.op_valid      = 1'b0;
        bus.op_unit       = '0;
        bus.op_tag        = '0;
        bus.op_rs1        = '0;
        bus.op_rs2        = '0;
        bus.unit_accepted = '1;
        for (int u = 0; u < NUM_UNITS; u++) next_res[u] = '0;

        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_wb_tag", 64'(bus.wb_tag), 64'd0);
        chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
        chk("rst_proto_err", 64'(bus.proto_err), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_order", 64'(bus.unit_order), 64'd0);
        chk("rst_slots", 64'(dbg), 64'd0);
        to_pos();

        // fmul 2.0*3.0 = 6.0, writeback three cycles after the handshake
        base = wb_cnt;
        issue(FMUL, 6'd5, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, ha);
        wait_wb(base + 1);
        chk("fmul_wb_cycle", 64'(wb_log_cyc[base]), 64'(ha + 3));
        @(negedge clk);
        chk("fmul_idle_busy", 64'(bus.busy), 64'd0);
        to_pos();

        // fadd (1+2) then fmul (3*4): fmul finishes first but writes back second
        base = wb_cnt;
        issue(FADD, 6'd1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, ha);
        issue(FMUL, 6'd2, 32'h4040_0000, 32'h4080_0000, 32'h4140_0000, hb);
        chk("order_back_to_back", 64'(hb), 64'(ha + 1));
        do @(negedge clk); while (cyc < ha + 4);
        chk("order_fmul_held", 64'(dbg[1:0]), 64'(SLOT_DONE));
        chk("order_fadd_pending", 64'(dbg[3:2]), 64'(SLOT_PENDING));
        to_pos();
        wait_wb(base + 2);
        chk("order_tag0", 64'(wb_log_tag[base]), 64'd1);
        chk("order_cyc0", 64'(wb_log_cyc[base]), 64'(ha + 5));
        chk("order_tag1", 64'(wb_log_tag[base + 1]), 64'd2);
        chk("order_cyc1", 64'(wb_log_cyc[base + 1]), 64'(ha + 6));

        // Second op to a busy fmul waits until the first has retired
        base = wb_cnt;
        issue(FMUL, 6'd7, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, ha);
        issue(FMUL, 6'd8, 32'h4080_0000, 32'h3F00_0000, 32'h4000_0000, hb);
        chk("busy_unit_hs", 64'(hb), 64'(ha + 3));
        wait_wb(base + 2);
        chk("busy_unit_wb0", 64'(wb_log_cyc[base]), 64'(ha + 3));
        chk("busy_unit_wb1", 64'(wb_log_cyc[base + 1]), 64'(hb + 3));

        // Four ops outstanding with done withheld: FIFO full blocks a fifth
        @(negedge clk);
        hold = '1;
        to_pos();
        base = wb_cnt;
        issue(FMUL,  6'd10, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, ha);
        issue(FADD,  6'd11, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, hb);
        issue(FDIV,  6'd12, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, hb);
        issue(FSQRT, 6'd13, 32'h4080_0000, 32'h0000_0000, 32'h4000_0000, hb);
        chk("full_hs_count", 64'(hb), 64'(ha + 3));
        fork
            issue(FMUL, 6'd14, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, h5);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("full_ready", 64'(bus.op_ready), 64'd0);
                    chk("full_order", 64'(bus.unit_order), 64'd0);
                end
                chk("full_busy", 64'(bus.busy), 64'd1);
                hold[0] = 1'b0;
                rel = cyc;
            end
        join
        chk("full_resume_hs", 64'(h5), 64'(rel + 2));
        @(negedge clk);
        hold = '0;
        to_pos();
        wait_wb(base + 5);
        for (int i = 0; i < 5; i++) begin
            chk("full_wb_order", 64'(wb_log_tag[base + i]), 64'(10 + i));
        end

        // Done from an idle unit is a protocol error and the flag sticks
        base = wb_cnt;
        @(negedge clk);
        chk("spur_pre_idle", 64'(bus.busy), 64'd0);
        spur = 4'b0100;
        @(negedge clk);
        chk("spur_not_yet", 64'(bus.proto_err), 64'd0);
        spur = '0;
        @(negedge clk);
        chk("spur_proto_err", 64'(bus.proto_err), 64'd1);
        chk("spur_no_wb", 64'(bus.wb_valid), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("spur_sticky", 64'(bus.proto_err), 64'd1);
        end
        chk("spur_slot2", 64'(dbg[5:4]), 64'(SLOT_EMPTY));
        chk("spur_wb_count", 64'(wb_cnt), 64'(base));
        hold = '1;
        to_pos();

        // Reset with three ops in flight discards them; a fresh op then runs normally
        issue(FADD,  6'd21, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, ha);
        issue(FDIV,  6'd22, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, ha);
        issue(FSQRT, 6'd23, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, ha);
        rstn = 1'b0;
        to_pos();
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_mid_proto_err", 64'(bus.proto_err), 64'd0);
        chk("rst_mid_slots", 64'(dbg), 64'd0);
        hold = '0;
        to_pos();
        base = wb_cnt;
        issue(FMUL, 6'd20, 32'h4040_0000, 32'h4040_0000, 32'h4110_0000, ha);
        wait_wb(base + 1);
        chk("post_rst_wb_cycle", 64'(wb_log_cyc[base]), 64'(ha + 3));
        @(negedge clk);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        chk("post_rst_proto_err", 64'(bus.proto_err), 64'd0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
